int_div_unit: RTL and testbench
===============================

# int_div_unit

Iterative RV32M divide/remainder unit in the EX stage. It produces the `done` signal that the pipeline hazard logic uses to freeze every stage while a multicycle operation runs. Accepts DIV, DIVU, REM and REMU, computes one quotient bit per cycle with radix-2 restoring division, and holds the result until the pipeline advances.

## Interface

Parameters:
- none (operand width fixed at 32)

Ports:
- clk  input  1  pipeline clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  valid divide-class instruction currently in EX (from ID/EX decode)
- op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled with start in IDLE
- rs1  input  32  dividend (forwarded EX operand A)
- rs2  input  32  divisor (forwarded EX operand B)
- flush  input  1  synchronous abort of in-flight operation
- done  output  1  low = stall whole pipeline; high = EX result may advance
- busy  output  1  registered, high in BUSY state
- result  output  32  quotient or remainder, valid while state is DONE

## Operation

- States: IDLE, BUSY, DONE.
- IDLE, start=0: done=1, nothing latched.
- IDLE, start=1: done=0 combinationally in the same cycle.
  - Latch the absolute values of the operands for signed ops, raw values for unsigned ops.
  - Latch op, quotient sign = rs1[31]^rs2[31] (signed ops, divisor≠0), and remainder sign = rs1[31] (signed ops).
  - Clear the 32-bit remainder accumulator and load the iteration counter with 31. Go to BUSY.
- BUSY:
  - Each cycle: shift {rem, dividend} left by 1 and trial-subtract the divisor from the 33-bit partial remainder.
  - If the partial remainder is non-negative, keep the difference and set the quotient bit to 1. Otherwise restore and set the bit to 0.
  - Decrement the counter. At counter 0, go to DONE.
  - done=0 throughout.
- DONE:
  - Apply sign correction as two's-complement negation of the quotient and/or remainder.
  - Register result: quotient for DIV/DIVU, remainder for REM/REMU.
  - done=1 for exactly this cycle. Go unconditionally to IDLE; start is still high here and must not restart the operation.
- Special results (RISC-V defined, no trap):
  - Divisor 0: quotient 0xFFFFFFFF, remainder = rs1.
  - DIV/REM 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0.
- flush=1 in any state forces IDLE on the next edge. result is unchanged and done follows the IDLE rule. flush has priority over start.
- done = (state==DONE) | (state==IDLE & ~start).

## Timing

- Normal latency: start seen in IDLE at cycle 0; BUSY in cycles 1–32; DONE in cycle 33. done is low for 33 cycles and high in cycle 33.
- Back-to-back divides: the second instruction enters EX in cycle 34 with state IDLE and starts immediately.
- Reset (async, any state, mid-operation included):
  - state=IDLE, busy=0, result=0, counter=0, all operand registers 0.
  - done=1 during reset while start=0.
- Result width rules:
  - 33-bit trial subtraction.
  - Negation is modulo 2^32, so |0x80000000| = 0x80000000 is handled as unsigned 2^31.

## Configuration

- DIV_FAST_SPECIAL_EN
  - Defined: divisor-zero and signed-overflow cases are detected in IDLE and skip BUSY. Sequence is IDLE→DONE, with a stall of 1 cycle and done high in cycle 1.
  - Undefined: these cases run the full 32 iterations. They produce the same special results via correction in DONE, with 33-cycle latency.
  - Results are identical in both builds; only latency differs.

## Test plan

- DIVU 100/7 then REMU 100/7 → results 14 and 2. done low cycles 0–32, high at 33. Second op starts at cycle 34.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD. REM same operands → 0xFFFFFFFF. REM 7/0xFFFFFFFE → 1.
- DIVU 5/0 → 0xFFFFFFFF and REMU 5/0 → 5.
  - With DIV_FAST_SPECIAL_EN: done high at cycle 1.
  - Without it: done high at cycle 33.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000. REM same operands → 0.
- Deassert rst_n at cycle 10 of a DIVU → state IDLE, busy=0, result=0. After release with start=1, a fresh operation completes 33 cycles later with the correct result.
- flush asserted at cycle 15 of a DIV → IDLE next cycle, result keeps its previous value, no DONE pulse. start held with flush=0 afterwards restarts the operation from cycle 0.

Source files
------------

// File: rtl/int_div_unit_if.sv
// int_div_unit_if: request/response bundle between the EX stage and the
// iterative divide unit. The pipeline side is the master, and the divider is
// the slave.
interface int_div_unit_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        flush;
  logic        done;
  logic        busy;
  logic [31:0] result;

  modport master (
    output start, op, rs1, rs2, flush,
    input  done, busy, result
  );

  modport slave (
    input  start, op, rs1, rs2, flush,
    output done, busy, result
  );
endinterface

// File: rtl/int_div_unit.sv
// int_div_unit: iterative RV32M DIV/DIVU/REM/REMU unit for the EX stage.
// Radix-2 restoring division runs on operand magnitudes and produces one
// quotient bit per cycle. Signs are fixed up as the result is registered.
// `done` drives the pipeline-wide freeze. It is low while an operation is in
// flight, and it is high when the EX result may advance.
//
// Build option: define DIV_FAST_SPECIAL_EN to resolve divide-by-zero and
// signed overflow (0x80000000 / -1) in IDLE and go straight to DONE. Results
// are identical either way. Without the macro, those cases run all 32
// iterations. They then fall out of the normal datapath plus sign correction.
module int_div_unit (
  input logic           clk,
  input logic           rst_n,
  int_div_unit_if.slave bus
);
  localparam int DATA_W = 32;
  localparam logic [DATA_W-1:0] ONE     = {{(DATA_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Two's-complement negation modulo 2^32. |0x80000000| stays 0x80000000,
  // and that pattern is read as the unsigned value 2^31 by the datapath.
  function automatic logic [DATA_W-1:0] neg_if(input logic [DATA_W-1:0] v,
                                               input logic              neg);
    return neg ? (~v + ONE) : v;
  endfunction

  // Magnitude of a signed operand, or the raw bits for unsigned ops.
  function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] v,
                                                input logic              is_signed);
    return neg_if(v, is_signed & v[DATA_W-1]);
  endfunction

  state_t              state;
  logic                busy_q;
  logic [4:0]          cnt_q;
  logic [1:0]          op_q;
  logic                q_neg_q;
  logic                r_neg_q;
  logic [DATA_W-1:0]   dvd_q;     // dividend shifting out, quotient shifting in
  logic [DATA_W-1:0]   dvs_q;     // divisor magnitude
  logic [DATA_W-1:0]   rem_q;     // partial remainder
  logic [DATA_W-1:0]   result_q;

  // Decode of the operands presented in IDLE
  logic                is_signed;
  logic [DATA_W-1:0]   a_abs;
  logic [DATA_W-1:0]   b_abs;
  logic                q_neg;
  logic                r_neg;

  // One restoring iteration
  logic [DATA_W:0]        shifted;
  logic signed [DATA_W:0] trial;
  logic                   q_bit;
  logic [DATA_W-1:0]      rem_next;
  logic [DATA_W-1:0]      quo_next;
  logic [DATA_W-1:0]      quo_fix;
  logic [DATA_W-1:0]      rem_fix;
  logic [DATA_W-1:0]      final_res;

`ifdef DIV_FAST_SPECIAL_EN
  logic                div_zero;
  logic                sgn_ovf;
  logic                fast_hit;
  logic [DATA_W-1:0]   fast_res;
`endif

  // Operand decode: magnitudes and result signs captured when start is accepted
  always_comb begin
    is_signed = ~bus.op[0];
    a_abs     = abs_val(bus.rs1, is_signed);
    b_abs     = abs_val(bus.rs2, is_signed);
    // A zero divisor yields an all-ones quotient, so the quotient is never negated.
    q_neg     = is_signed & (bus.rs1[DATA_W-1] ^ bus.rs2[DATA_W-1]) & (bus.rs2 != '0);
    r_neg     = is_signed & bus.rs1[DATA_W-1];
  end

  // Restoring step: shift {rem, dividend} left, trial-subtract on 33 bits, keep or restore
  always_comb begin
    shifted   = {rem_q, dvd_q[DATA_W-1]};
    trial     = $signed(shifted) - $signed({1'b0, dvs_q});
    q_bit     = ~trial[DATA_W];
    rem_next  = q_bit ? trial[DATA_W-1:0] : shifted[DATA_W-1:0];
    quo_next  = {dvd_q[DATA_W-2:0], q_bit};
    quo_fix   = neg_if(quo_next, q_neg_q);
    rem_fix   = neg_if(rem_next, r_neg_q);
    final_res = op_q[1] ? rem_fix : quo_fix;
  end

`ifdef DIV_FAST_SPECIAL_EN
  // Early detection of the two RISC-V special cases, resolved without iterating
  always_comb begin
    div_zero = (bus.rs2 == '0);
    sgn_ovf  = is_signed & (bus.rs1 == MIN_NEG) & (bus.rs2 == '1);
    fast_hit = div_zero | sgn_ovf;
    if (bus.op[1])
      fast_res = div_zero ? bus.rs1 : '0;
    else
      fast_res = div_zero ? '1 : MIN_NEG;
  end
`endif

  // Control FSM and datapath registers; flush overrides everything except reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      op_q     <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      result_q <= '0;
    end else if (bus.flush) begin
      state  <= S_IDLE;
      busy_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            op_q    <= bus.op;
            q_neg_q <= q_neg;
            r_neg_q <= r_neg;
            dvd_q   <= a_abs;
            dvs_q   <= b_abs;
            rem_q   <= '0;
            cnt_q   <= 5'd31;
`ifdef DIV_FAST_SPECIAL_EN
            if (fast_hit) begin
              state    <= S_DONE;
              busy_q   <= 1'b0;
              result_q <= fast_res;
            end else begin
              state  <= S_BUSY;
              busy_q <= 1'b1;
            end
`else
            state  <= S_BUSY;
            busy_q <= 1'b1;
`endif
          end
        end
        S_BUSY: begin
          rem_q <= rem_next;
          dvd_q <= quo_next;
          cnt_q <= cnt_q - 5'd1;
          // The last iteration's corrected value is registered so it is valid in DONE.
          if (cnt_q == 5'd0) begin
            state    <= S_DONE;
            busy_q   <= 1'b0;
            result_q <= final_res;
          end
        end
        S_DONE: begin
          // A start that is still high here belongs to the finishing instruction.
          state <= S_IDLE;
        end
        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // The stall is released the same cycle an idle EX stage holds no divide.
  assign bus.done   = (state == S_DONE) | ((state == S_IDLE) & ~bus.start);
  assign bus.busy   = busy_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_int_div_unit.sv
// tb_int_div_unit: self-checking bench for int_div_unit with directed and
// randomized operations checked against a plain-arithmetic reference model.
module tb_int_div_unit;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

`ifdef DIV_FAST_SPECIAL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  always #5 clk = ~clk;

  int_div_unit_if bus ();

  int_div_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference: RISC-V division semantics from 64-bit integer arithmetic
  function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) begin
      q = 64'hFFFF_FFFF;
      r = longint'({32'd0, a});
    end else begin
      if (!o[0]) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
      end else begin
        sa = longint'({32'd0, a});
        sb = longint'({32'd0, b});
      end
      q = sa / sb;
      r = sa % sb;
    end
    return o[1] ? r[31:0] : q[31:0];
  endfunction

  function automatic bit is_special(input logic [1:0] o, input logic [31:0] a,
                                    input logic [31:0] b);
    return (b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic int exp_lat(input logic [1:0] o, input logic [31:0] a,
                                 input logic [31:0] b);
    return (FAST && is_special(o, a, b)) ? 1 : 33;
  endfunction

  // Present an operation at cycle 0 and report the cycle where done rises.
  // The task returns just after the edge that ends the DONE cycle. start is left high.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int busy_cyc);
    bus.start = 1'b1;
    bus.op    = o;
    bus.rs1   = a;
    bus.rs2   = b;
    lat       = -1;
    busy_cyc  = 0;
    res       = 32'hDEAD_BEEF;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.busy === 1'b1) busy_cyc++;
      if (bus.done === 1'b1) begin
        lat = c;
        res = bus.result;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic go_idle();
    bus.start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.op    = 2'd0;
    bus.rs1   = 32'd0;
    bus.rs2   = 32'd0;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.result !== 32'd0) begin errors++; $display("FAIL reset_result got %h want 0", bus.result); end
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL reset_done got %b want 1", bus.done); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] res;
    int lat, bc;
    run_op(2'd1, 32'd100, 32'd7, res, lat, bc);
    checks++; if (res !== 32'd14) begin errors++; $display("FAIL b2b_divu got %h want 0000000e", res); end
    checks++; if (lat !== 33) begin errors++; $display("FAIL b2b_divu_lat got %0d want 33", lat); end
    checks++; if (bc !== 32) begin errors++; $display("FAIL b2b_divu_busy got %0d want 32", bc); end
    run_op(2'd3, 32'd100, 32'd7, res, lat, bc);
    checks++; if (res !== 32'd2) begin errors++; $display("FAIL b2b_remu got %h want 00000002", res); end
    checks++; if (lat !== 33) begin errors++; $display("FAIL b2b_remu_lat got %0d want 33", lat); end
    go_idle();
    @(negedge clk);
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL idle_done got %b want 1", bus.done); end
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [1:0]  t_op [10] = '{2'd0, 2'd2, 2'd2, 2'd1, 2'd3, 2'd0, 2'd2, 2'd0, 2'd2, 2'd1};
    logic [31:0] t_a  [10] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd5, 32'd5,
                               32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
                               32'hFFFF_FFFF};
    logic [31:0] t_b  [10] = '{32'd2, 32'd2, 32'hFFFF_FFFE, 32'd0, 32'd0,
                               32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd1};
    logic [31:0] t_r  [10] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd5,
                               32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'h8000_0000,
                               32'hFFFF_FFFF};
    logic [31:0] res;
    int lat, bc;
    for (int i = 0; i < 10; i++) begin
      run_op(t_op[i], t_a[i], t_b[i], res, lat, bc);
      go_idle();
      checks++;
      if (res !== t_r[i]) begin
        errors++;
        $display("FAIL dir_res[%0d] got %h want %h", i, res, t_r[i]);
      end
      checks++;
      if (lat !== exp_lat(t_op[i], t_a[i], t_b[i])) begin
        errors++;
        $display("FAIL dir_lat[%0d] got %0d want %0d", i, lat, exp_lat(t_op[i], t_a[i], t_b[i]));
      end
    end
  endtask

  task automatic test_random();
    logic [1:0]  o;
    logic [31:0] a, b, res, want;
    int lat, bc, sel;
    for (int i = 0; i < 30; i++) begin
      o   = 2'($urandom_range(0, 3));
      sel = int'($urandom_range(0, 7));
      a   = (sel == 7) ? 32'h8000_0000 : $urandom;
      case (sel)
        0:       b = 32'd0;
        1, 7:    b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 15));
        3:       b = a >> $urandom_range(0, 8);
        default: b = $urandom;
      endcase
      want = ref_div(o, a, b);
      run_op(o, a, b, res, lat, bc);
      if ($urandom_range(0, 1) == 0) go_idle();
      checks++;
      if (res !== want) begin
        errors++;
        $display("FAIL rnd_res[%0d] op %0d %h/%h got %h want %h", i, o, a, b, res, want);
      end
      checks++;
      if (lat !== exp_lat(o, a, b)) begin
        errors++;
        $display("FAIL rnd_lat[%0d] got %0d want %0d", i, lat, exp_lat(o, a, b));
      end
    end
    go_idle();
  endtask

  task automatic test_reset_mid();
    logic [31:0] res;
    int lat, bc;
    bus.start = 1'b1;
    bus.op    = 2'd1;
    bus.rs1   = 32'd1000;
    bus.rs2   = 32'd3;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", bus.busy); end
    checks++; if (bus.result !== 32'd0) begin errors++; $display("FAIL rstmid_result got %h want 0", bus.result); end
    bus.start = 1'b0;
    #1;
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL rstmid_done got %b want 1", bus.done); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_op(2'd1, 32'd1000, 32'd3, res, lat, bc);
    go_idle();
    checks++; if (res !== 32'd333) begin errors++; $display("FAIL rstmid_res got %h want 0000014d", res); end
    checks++; if (lat !== 33) begin errors++; $display("FAIL rstmid_lat got %0d want 33", lat); end
  endtask

  task automatic test_flush();
    logic [31:0] res;
    int lat, bc, pulses;
    run_op(2'd1, 32'd100, 32'd7, res, lat, bc);
    go_idle();
    // Flush beats start while idle
    bus.start = 1'b1;
    bus.flush = 1'b1;
    bus.op    = 2'd1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_idle_busy got %b want 0", bus.busy); end
    @(posedge clk); #1;
    // Abort a DIV at cycle 15, then restart it from start still held high
    pulses    = 0;
    bus.start = 1'b1;
    bus.op    = 2'd0;
    bus.rs1   = 32'hFFFF_FF9C;
    bus.rs2   = 32'd7;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (bus.done !== 1'b0) pulses++;
      @(posedge clk); #1;
    end
    bus.flush = 1'b1;
    @(negedge clk);
    if (bus.done !== 1'b0) pulses++;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    @(negedge clk);
    if (bus.done !== 1'b0) pulses++;
    checks++; if (pulses !== 0) begin errors++; $display("FAIL flush_done_pulses got %0d want 0", pulses); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b want 0", bus.busy); end
    checks++; if (bus.result !== 32'd14) begin errors++; $display("FAIL flush_result got %h want 0000000e", bus.result); end
    lat = -1;
    for (int c = 1; c < 40; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (bus.done === 1'b1) begin
        lat = c;
        res = bus.result;
        break;
      end
    end
    @(posedge clk); #1;
    go_idle();
    checks++; if (lat !== 33) begin errors++; $display("FAIL flush_restart_lat got %0d want 33", lat); end
    checks++; if (res !== 32'hFFFF_FFF2) begin errors++; $display("FAIL flush_restart_res got %h want fffffff2", res); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_directed();
    test_random();
    test_reset_mid();
    test_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
